// File: rtl/prescaler_ctrl.sv
// Selectable-ratio prescaler controller: divide-by-2^sel tick enable and square-wave output,
// with ratio changes accepted by handshake and applied only at the end of an output period.
module prescaler_ctrl #(
    parameter int unsigned         SEL_W     = 2,
    parameter logic [SEL_W-1:0]    RESET_SEL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [SEL_W-1:0] cfg_sel,
    output logic             cfg_ready,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy,
    output logic             tick,
    output logic             div_out
);

    localparam int unsigned CNT_W = 2 ** SEL_W - 1;

    typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic               div_q, div_d;
    logic [CNT_W-1:0]   term;
    logic               wrap;
    logic               hs;

    // 2^cur_sel - 1 as a mask of cur_sel low ones
    assign term      = ~({CNT_W{1'b1}} << cur_sel_q);
    assign wrap      = (cnt_q == term);
    assign cfg_ready = (state_q != StPend);
    assign busy      = (state_q == StPend);
    assign hs        = cfg_valid && cfg_ready;

    assign cur_sel = cur_sel_q;
    assign tick    = tick_q;
    assign div_out = div_q;

    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        pend_sel_d = pend_sel_q;
        cnt_d      = cnt_q;
        tick_d     = tick_q;
        div_d      = div_q;

        unique case (state_q)
            StIdle: begin
                cnt_d  = '0;
                tick_d = 1'b0;
                div_d  = 1'b0;
                if (hs) cur_sel_d = cfg_sel;
                if (run) state_d = StRun;
            end
            StRun, StPend: begin
                if (!run) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    tick_d  = 1'b0;
                    div_d   = 1'b0;
                    if (state_q == StPend) begin
                        cur_sel_d = pend_sel_q;
                    end else if (hs) begin
                        cur_sel_d = cfg_sel;
                    end
                end else if (state_q == StPend && wrap && div_q) begin
                    // Falling toggle of div_out closes the period; switch ratio here.
                    state_d   = StRun;
                    cur_sel_d = pend_sel_q;
                    cnt_d     = '0;
                    tick_d    = 1'b1;
                    div_d     = 1'b0;
                end else begin
                    if (wrap) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        div_d  = ~div_q;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        tick_d = 1'b0;
                    end
                    if (hs) begin
                        pend_sel_d = cfg_sel;
                        state_d    = StPend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cur_sel_q  <= RESET_SEL;
            pend_sel_q <= '0;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            div_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            pend_sel_q <= pend_sel_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            div_q      <= div_d;
        end
    end

endmodule

// File: tb/tb_prescaler_ctrl.sv
// Self-checking bench for prescaler_ctrl: directed test-plan sequences plus random traffic,
// compared against an elapsed-cycle reference model.
module tb_prescaler_ctrl;

    localparam int unsigned SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [SEL_W-1:0] cfg_sel = '0;
    logic             cfg_ready;
    logic [SEL_W-1:0] cur_sel;
    logic             busy;
    logic             tick;
    logic             div_out;

    int checks = 0;
    int failures = 0;

    // Model: mode 0=idle 1=run 2=pending; age = edges since counting (re)started.
    int m_mode = 0;
    int m_sel  = 0;
    int m_pend = 0;
    int m_age  = 0;
    int m_tick = 0;
    int m_div  = 0;

    prescaler_ctrl #(.SEL_W(SEL_W), .RESET_SEL(2'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_sel   (cfg_sel),
        .cfg_ready (cfg_ready),
        .cur_sel   (cur_sel),
        .busy      (busy),
        .tick      (tick),
        .div_out   (div_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_sel = 0; m_pend = 0; m_age = 0; m_tick = 0; m_div = 0;
    endtask

    task automatic model_edge(input int r, input int v, input int s);
        int p;
        int hs;
        p  = 1 << m_sel;
        hs = (v != 0) && (m_mode != 2);
        if (m_mode == 0) begin
            if (hs) m_sel = s;
            m_tick = 0; m_div = 0;
            if (r != 0) begin m_mode = 1; m_age = 0; end
        end else if (r == 0) begin
            if (m_mode == 2) m_sel = m_pend;
            else if (hs) m_sel = s;
            m_mode = 0; m_tick = 0; m_div = 0;
        end else begin
            m_age++;
            if (m_mode == 2 && (m_age % p) == 0 && ((m_age / p) % 2) == 0) begin
                m_sel = m_pend; m_mode = 1; m_age = 0; m_tick = 1; m_div = 0;
            end else begin
                m_tick = ((m_age % p) == 0) ? 1 : 0;
                m_div  = (m_age / p) % 2;
                if (hs) begin m_pend = s; m_mode = 2; end
            end
        end
    endtask

    // Called just after a falling edge; drives inputs for one rising edge and checks outputs.
    task automatic cycle(input int r, input int v, input int s);
        run       = 1'(r);
        cfg_valid = 1'(v);
        cfg_sel   = SEL_W'(s);
        check("cfg_ready", 32'(cfg_ready), 32'(m_mode != 2));
        check("busy", 32'(busy), 32'(m_mode == 2));
        @(posedge clk);
        model_edge(r, v, s);
        @(negedge clk);
        check("tick", 32'(tick), 32'(m_tick));
        check("div_out", 32'(div_out), 32'(m_div));
        check("cur_sel", 32'(cur_sel), 32'(m_sel));
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_div", 32'(div_out), 32'd0);
        check("rst_cur_sel", 32'(cur_sel), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_div", 32'(div_out), 32'd0);
        check("reset_cur_sel", 32'(cur_sel), 32'd0);
        check("reset_ready", 32'(cfg_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);

        // Divide-by-4 run.
        cycle(0, 1, 2);
        repeat (20) cycle(1, 0, 0);

        // sel=3, change to 1 mid-period; further requests in PEND are ignored.
        cycle(0, 0, 0);
        cycle(0, 1, 3);
        repeat (3) cycle(1, 0, 0);
        cycle(1, 1, 1);
        repeat (8) cycle(1, 1, 0);
        repeat (12) cycle(1, 0, 0);

        // run drops while pending: pending ratio applied immediately.
        cycle(0, 1, 3);
        repeat (5) cycle(1, 0, 0);
        cycle(1, 1, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        repeat (6) cycle(1, 0, 0);

        // Reset while pending with div_out high.
        cycle(0, 1, 3);
        repeat (9) cycle(1, 0, 0);
        cycle(1, 1, 2);
        check("pend_div_high", 32'(div_out), 32'd1);
        async_reset();

        // Handshake in the same cycle run rises.
        cycle(1, 1, 2);
        repeat (10) cycle(1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 19) != 0) ? 1 : 0,
                  ($urandom_range(0, 9) < 3) ? 1 : 0,
                  int'($urandom_range(0, 3)));
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
